// File: rtl/mem_wb_stage.sv
// Memory-access / writeback stage: one outstanding data-memory request, load alignment, commit record.
// Optional MEM_BUS_ERR_EN: a bus error on the response turns the record into a trap (cause 5 load, 7 store).
module mem_wb_stage #(
   parameter int XLEN = 32
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [73:0]     in_alu,
   input  logic [4:0]      in_rd,
   input  logic [2:0]      in_funct3,
   input  logic [1:0]      in_memaccess,
   input  logic [XLEN-1:0] in_store_data,
   output logic            dmem_req_valid,
   input  logic            dmem_req_ready,
   output logic            dmem_req_we,
   output logic [31:0]     dmem_req_addr,
   output logic [3:0]      dmem_req_wstrb,
   output logic [31:0]     dmem_req_wdata,
   input  logic            dmem_rsp_valid,
   input  logic [31:0]     dmem_rsp_rdata,
   input  logic            dmem_rsp_err,
   output logic            wb_valid,
   input  logic            wb_ready,
   output logic [4:0]      wb_rd,
   output logic            wb_we,
   output logic [31:0]     wb_data,
   output logic            wb_trap,
   output logic [5:0]      wb_cause,
   output logic            wb_redirect
);

   typedef enum logic [2:0] {S_IDLE, S_REQ, S_RSP, S_HOLD, S_DRAIN} state_t;

   state_t      state, state_nx;
   logic        accept;
   logic        is_store;
   logic [1:0]  in_type;
   logic [31:0] in_ea;
   logic [2:0]  f3_p1;
   logic [1:0]  lane_p1;
   logic        store_p1;
   logic        unused_bits;

   function automatic logic [31:0] load_align(input logic [31:0] rdata,
                                              input logic [1:0]  lane,
                                              input logic [2:0]  f3);
      logic [31:0]        shifted;
      logic signed [7:0]  b;
      logic signed [15:0] h;
      logic signed [31:0] sext;
      logic [31:0]        r;
      shifted = rdata >> {lane, 3'b000};
      b = $signed(shifted[7:0]);
      h = $signed(lane[1] ? rdata[31:16] : rdata[15:0]);
      case (f3[1:0])
         2'd0: begin
            sext = b;
            r = f3[2] ? {24'd0, b} : sext;
         end
         2'd1: begin
            sext = h;
            r = f3[2] ? {16'd0, h} : sext;
         end
         default: r = rdata;
      endcase
      return r;
   endfunction

   function automatic logic [3:0] store_strb(input logic [1:0] ea_lo, input logic [2:0] f3);
      case (f3[1:0])
         2'd0:    return 4'b0001 << ea_lo;
         2'd1:    return 4'b0011 << {ea_lo[1], 1'b0};
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] store_lanes(input logic [31:0] d, input logic [2:0] f3);
      case (f3[1:0])
         2'd0:    return {4{d[7:0]}};
         2'd1:    return {2{d[15:0]}};
         default: return d;
      endcase
   endfunction

   assign in_type  = in_alu[72:71];
   assign in_ea    = in_alu[38:7];
   assign is_store = (in_memaccess == 2'd1);
   assign in_ready = (state == S_IDLE);
   assign accept   = (state == S_IDLE) && in_valid && !flush;

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (accept) state_nx = (in_type == 2'd0) ? S_REQ : S_HOLD;
         S_REQ: begin
            // A flush that coincides with the handshake still leaves a response to absorb
            if (dmem_req_ready) state_nx = flush ? S_DRAIN : S_RSP;
            else if (flush)     state_nx = S_IDLE;
         end
         S_RSP: begin
            if (dmem_rsp_valid) state_nx = flush ? S_IDLE : S_HOLD;
            else if (flush)     state_nx = S_DRAIN;
         end
         S_HOLD:  if (flush || wb_ready) state_nx = S_IDLE;
         S_DRAIN: if (dmem_rsp_valid) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state          <= S_IDLE;
         dmem_req_valid <= 1'b0;
         dmem_req_we    <= 1'b0;
         dmem_req_addr  <= '0;
         dmem_req_wstrb <= '0;
         dmem_req_wdata <= '0;
         wb_valid       <= 1'b0;
         wb_rd          <= '0;
         wb_we          <= 1'b0;
         wb_data        <= '0;
         wb_trap        <= 1'b0;
         wb_cause       <= '0;
         wb_redirect    <= 1'b0;
      end else begin
         state          <= state_nx;
         dmem_req_valid <= (state_nx == S_REQ);
         wb_valid       <= (state_nx == S_HOLD);
         if (accept) begin
            wb_rd          <= in_rd;
            wb_redirect    <= in_alu[0];
            wb_cause       <= in_alu[6:1];
            wb_data        <= in_alu[70:39];
            wb_we          <= (in_type == 2'd2) && (in_rd != 5'd0);
            wb_trap        <= (in_type == 2'd3);
            dmem_req_addr  <= {in_ea[31:2], 2'b00};
            dmem_req_we    <= is_store;
            dmem_req_wstrb <= is_store ? store_strb(in_ea[1:0], in_funct3) : 4'b0000;
            dmem_req_wdata <= is_store ? store_lanes(in_store_data, in_funct3) : 32'd0;
         end
         if (state == S_RSP && dmem_rsp_valid) begin
            wb_data <= store_p1 ? 32'd0 : load_align(dmem_rsp_rdata, lane_p1, f3_p1);
            wb_we   <= !store_p1 && (wb_rd != 5'd0);
            wb_trap <= 1'b0;
`ifdef MEM_BUS_ERR_EN
            if (dmem_rsp_err) begin
               wb_trap  <= 1'b1;
               wb_we    <= 1'b0;
               wb_cause <= store_p1 ? 6'd7 : 6'd5;
            end
`endif
         end
      end
   end

   // Access attributes needed once the response returns
   always_ff @(posedge CLK) begin
      if (accept) begin
         f3_p1    <= in_funct3;
         lane_p1  <= in_ea[1:0];
         store_p1 <= is_store;
      end
   end

`ifdef MEM_BUS_ERR_EN
   assign unused_bits = in_alu[73];
`else
   assign unused_bits = ^{in_alu[73], dmem_rsp_err};
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: directed cases followed by randomized traffic against a reference model.
module tb_mem_wb_stage;

   logic        CLK = 1'b0;
   logic        RST;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [73:0] in_alu;
   logic [4:0]  in_rd;
   logic [2:0]  in_funct3;
   logic [1:0]  in_memaccess;
   logic [31:0] in_store_data;
   logic        dmem_req_valid;
   logic        dmem_req_ready;
   logic        dmem_req_we;
   logic [31:0] dmem_req_addr;
   logic [3:0]  dmem_req_wstrb;
   logic [31:0] dmem_req_wdata;
   logic        dmem_rsp_valid;
   logic [31:0] dmem_rsp_rdata;
   logic        dmem_rsp_err;
   logic        wb_valid;
   logic        wb_ready;
   logic [4:0]  wb_rd;
   logic        wb_we;
   logic [31:0] wb_data;
   logic        wb_trap;
   logic [5:0]  wb_cause;
   logic        wb_redirect;

   always #5 CLK = ~CLK;

   mem_wb_stage #(.XLEN(32)) dut (
      .CLK(CLK), .RST(RST), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_alu(in_alu), .in_rd(in_rd),
      .in_funct3(in_funct3), .in_memaccess(in_memaccess), .in_store_data(in_store_data),
      .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready), .dmem_req_we(dmem_req_we),
      .dmem_req_addr(dmem_req_addr), .dmem_req_wstrb(dmem_req_wstrb), .dmem_req_wdata(dmem_req_wdata),
      .dmem_rsp_valid(dmem_rsp_valid), .dmem_rsp_rdata(dmem_rsp_rdata), .dmem_rsp_err(dmem_rsp_err),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_we(wb_we), .wb_data(wb_data),
      .wb_trap(wb_trap), .wb_cause(wb_cause), .wb_redirect(wb_redirect)
   );

   typedef struct {
      logic [4:0]  rd;
      logic        we;
      logic [31:0] data;
      logic        trap;
      logic [5:0]  cause;
      logic        redirect;
   } wb_exp_t;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
   } req_exp_t;

   wb_exp_t  wb_q[$];
   req_exp_t req_q[$];
   int n_vec = 0;
   int n_err = 0;
   int ready_pct = 100;
   int wb_pct = 100;
   int rsp_delay_cfg = -1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Bus model contents: a few pinned words, everything else a hash of the address
   function automatic logic [31:0] rdata_of(input logic [31:0] a);
      if (a == 32'h1000) return 32'h80AA_BBCC;
      if (a == 32'h3000) return 32'h0BAD_F00D;
      return (a * 32'h9E37_79B1) ^ 32'hA5C3_0F96;
   endfunction

   function automatic logic err_of(input logic [31:0] a);
      logic [31:0] h;
      if (a == 32'h3000) return 1'b1;
      if (a == 32'h1000 || a == 32'h2000 || a == 32'h4000) return 1'b0;
      h = a * 32'h9E37_79B1;
      return (h[31:28] == 4'hF);
   endfunction

   function automatic wb_exp_t model_wb(input logic [1:0] typ, input logic [4:0] rd, input logic [2:0] f3,
                                        input logic [1:0] ma, input logic [31:0] res, input logic [31:0] ea,
                                        input logic [5:0] cause, input logic redir);
      wb_exp_t e;
      logic [31:0] word, v, waddr;
      e.rd = rd; e.redirect = redir; e.cause = cause;
      e.trap = (typ == 2'd3);
      e.we = (typ == 2'd2) && (rd != 0);
      e.data = res;
      if (typ == 2'd0) begin
         waddr = ea & 32'hFFFF_FFFC;
         word = rdata_of(waddr);
         if (ma == 2'd1) begin
            e.we = 1'b0; e.data = 32'd0;
         end else begin
            if (f3 == 3'd0 || f3 == 3'd4) begin
               v = (word >> (32'(ea[1:0]) * 8)) & 32'hFF;
               if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
            end else if (f3 == 3'd1 || f3 == 3'd5) begin
               v = (word >> (32'(ea[1]) * 16)) & 32'hFFFF;
               if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
            end else v = word;
            e.data = v;
            e.we = (rd != 0);
         end
`ifdef MEM_BUS_ERR_EN
         if (err_of(waddr)) begin
            e.trap = 1'b1; e.we = 1'b0; e.cause = (ma == 2'd1) ? 6'd7 : 6'd5;
         end
`endif
      end
      return e;
   endfunction

   function automatic req_exp_t model_req(input logic [2:0] f3, input logic [1:0] ma,
                                          input logic [31:0] ea, input logic [31:0] sd);
      req_exp_t r;
      r.addr = ea & 32'hFFFF_FFFC;
      r.we = (ma == 2'd1);
      r.wstrb = 4'd0; r.wdata = 32'd0;
      if (r.we) begin
         if (f3 == 3'd0) begin
            r.wstrb = 4'(1 << ea[1:0]); r.wdata = (sd & 32'hFF) * 32'h0101_0101;
         end else if (f3 == 3'd1) begin
            r.wstrb = 4'(3 << (ea[1] * 2)); r.wdata = (sd & 32'hFFFF) * 32'h0001_0001;
         end else begin
            r.wstrb = 4'hF; r.wdata = sd;
         end
      end
      return r;
   endfunction

   task automatic issue(input logic [1:0] typ, input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] ma,
                        input logic [31:0] res, input logic [31:0] ea, input logic [31:0] sd,
                        input logic [5:0] cause, input logic redir, input bit push_wb);
      bit acc = 0;
      @(posedge CLK); #1;
      in_valid = 1'b1;
      in_alu = {1'b1, typ, res, ea, cause, redir};
      in_rd = rd; in_funct3 = f3; in_memaccess = ma; in_store_data = sd;
      for (int k = 0; k < 200 && !acc; k++) begin
         @(negedge CLK);
         if (in_ready && !flush) acc = 1;
         else begin @(posedge CLK); #1; end
      end
      if (!acc) check("accept_timeout", 64'd0, 64'd1);
      else begin
         if (push_wb) wb_q.push_back(model_wb(typ, rd, f3, ma, res, ea, cause, redir));
         if (typ == 2'd0) req_q.push_back(model_req(f3, ma, ea, sd));
      end
      @(posedge CLK); #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_wb();
      bit seen = 0;
      for (int k = 0; k < 100 && !seen; k++) begin
         @(negedge CLK);
         if (wb_valid) seen = 1;
      end
      if (!seen) check("wb_timeout", 64'd0, 64'd1);
   endtask

   task automatic wait_idle();
      bit seen = 0;
      for (int k = 0; k < 200 && !seen; k++) begin
         @(posedge CLK); #1;
         if (in_ready && !wb_valid) seen = 1;
      end
      if (!seen) check("idle_timeout", 64'd0, 64'd1);
   endtask

   // Data-memory responder: single outstanding request, programmable or random response delay
   initial begin
      bit fire, pend;
      int cnt;
      logic [31:0] fa, paddr;
      pend = 0; cnt = 0; paddr = '0;
      dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rsp_rdata = '0; dmem_rsp_err = 1'b0;
      forever begin
         @(negedge CLK);
         fire = dmem_req_valid && dmem_req_ready && !RST;
         fa = dmem_req_addr;
         @(posedge CLK); #1;
         dmem_rsp_valid = 1'b0;
         dmem_rsp_rdata = $urandom;
         dmem_rsp_err = 1'($urandom_range(0, 1));
         if (fire) begin
            pend = 1; paddr = fa;
            cnt = (rsp_delay_cfg >= 0) ? rsp_delay_cfg : int'($urandom_range(0, 3));
         end
         if (pend) begin
            if (cnt == 0) begin
               dmem_rsp_valid = 1'b1;
               dmem_rsp_rdata = rdata_of(paddr);
               dmem_rsp_err = err_of(paddr);
               pend = 0;
            end else cnt--;
         end
         dmem_req_ready = ($urandom_range(0, 99) < ready_pct);
      end
   end

   initial begin
      wb_ready = 1'b0;
      forever begin
         @(posedge CLK); #1;
         wb_ready = ($urandom_range(0, 99) < wb_pct);
      end
   end

   // Writeback monitor: stability while stalled, scoreboard compare on handshake
   initial begin
      bit held = 0;
      logic [45:0] last;
      wb_exp_t e;
      forever begin
         @(negedge CLK);
         if (RST) begin held = 0; continue; end
         if (wb_valid) begin
            if (held) check("wb_stable", 64'({wb_rd, wb_we, wb_data, wb_trap, wb_cause, wb_redirect}), 64'(last));
            if (wb_ready) begin
               if (wb_q.size() == 0) check("wb_unexpected", 64'd1, 64'd0);
               else begin
                  e = wb_q.pop_front();
                  check("wb_rd", 64'(wb_rd), 64'(e.rd));
                  check("wb_we", 64'(wb_we), 64'(e.we));
                  check("wb_data", 64'(wb_data), 64'(e.data));
                  check("wb_trap", 64'(wb_trap), 64'(e.trap));
                  check("wb_cause", 64'(wb_cause), 64'(e.cause));
                  check("wb_redirect", 64'(wb_redirect), 64'(e.redirect));
               end
               held = 0;
            end else begin
               held = 1;
               last = {wb_rd, wb_we, wb_data, wb_trap, wb_cause, wb_redirect};
            end
         end else held = 0;
      end
   end

   // Request monitor
   initial begin
      bit held = 0;
      logic [68:0] last;
      req_exp_t r;
      forever begin
         @(negedge CLK);
         if (RST) begin held = 0; continue; end
         if (dmem_req_valid) begin
            if (held) check("req_stable", 64'({dmem_req_we, dmem_req_addr, dmem_req_wstrb, dmem_req_wdata}),
                            64'(last));
            if (dmem_req_ready) begin
               if (req_q.size() == 0) check("req_unexpected", 64'd1, 64'd0);
               else begin
                  r = req_q.pop_front();
                  check("req_addr", 64'(dmem_req_addr), 64'(r.addr));
                  check("req_we", 64'(dmem_req_we), 64'(r.we));
                  if (r.we) begin
                     check("req_wstrb", 64'(dmem_req_wstrb), 64'(r.wstrb));
                     check("req_wdata", 64'(dmem_req_wdata), 64'(r.wdata));
                  end
               end
               held = 0;
            end else begin
               held = 1;
               last = {dmem_req_we, dmem_req_addr, dmem_req_wstrb, dmem_req_wdata};
            end
         end else held = 0;
      end
   end

   initial begin
      logic [1:0]  typ, ma;
      logic [2:0]  f3;
      logic [31:0] ea;
      logic [2:0]  ld_f3 [5];
      ld_f3[0] = 3'd0; ld_f3[1] = 3'd1; ld_f3[2] = 3'd2; ld_f3[3] = 3'd4; ld_f3[4] = 3'd5;
      RST = 1'b1; flush = 1'b0; in_valid = 1'b0; in_alu = '0; in_rd = '0;
      in_funct3 = '0; in_memaccess = '0; in_store_data = '0;
      repeat (3) @(posedge CLK);
      #1;
      check("rst_in_ready", 64'(in_ready), 64'd1);
      check("rst_req_valid", 64'(dmem_req_valid), 64'd0);
      check("rst_wb_valid", 64'(wb_valid), 64'd0);
      check("rst_wb_flags", 64'({wb_we, wb_trap, wb_redirect}), 64'd0);
      check("rst_wb_fields", 64'({wb_rd, wb_cause, wb_data}), 64'd0);
      check("rst_req_fields", 64'({dmem_req_we, dmem_req_addr, dmem_req_wstrb, dmem_req_wdata}), 64'd0);
      RST = 1'b0;

      // Regular result: one-cycle latency, back to idle right after the handshake
      issue(2'd2, 5'd3, 3'd0, 2'd0, 32'h1234_5678, 32'h40, 32'd0, 6'd0, 1'b0, 1);
      check("reg_wb_valid", 64'(wb_valid), 64'd1);
      check("reg_wb_data", 64'(wb_data), 64'h1234_5678);
      check("reg_wb_we", 64'(wb_we), 64'd1);
      @(posedge CLK); #1;
      check("reg_back_idle", 64'(in_ready), 64'd1);

      // Signed and unsigned byte loads from the top lane
      issue(2'd0, 5'd5, 3'd0, 2'd0, 32'h0, 32'h1003, 32'd0, 6'd0, 1'b0, 1);
      check("lb_req_addr", 64'(dmem_req_addr), 64'h1000);
      wait_wb();
      check("lb_data", 64'(wb_data), 64'hFFFF_FF80);
      wait_idle();
      issue(2'd0, 5'd5, 3'd4, 2'd0, 32'h0, 32'h1003, 32'd0, 6'd0, 1'b0, 1);
      wait_wb();
      check("lbu_data", 64'(wb_data), 64'h0000_0080);
      wait_idle();

      // Halfword store held against a stalled bus
      ready_pct = 0;
      issue(2'd0, 5'd6, 3'd1, 2'd1, 32'h0, 32'h2002, 32'hDEAD_BEEF, 6'd0, 1'b0, 1);
      for (int i = 0; i < 3; i++) begin
         check("sh_req_valid", 64'(dmem_req_valid), 64'd1);
         check("sh_wstrb", 64'(dmem_req_wstrb), 64'hC);
         check("sh_wdata", 64'(dmem_req_wdata), 64'hBEEF_BEEF);
         @(posedge CLK); #1;
      end
      ready_pct = 100;
      wait_wb();
      check("sh_wb_we", 64'(wb_we), 64'd0);
      wait_idle();

      // Flush while waiting for the response: response drained silently
      rsp_delay_cfg = 2;
      issue(2'd0, 5'd7, 3'd2, 2'd0, 32'h0, 32'h4000, 32'd0, 6'd0, 1'b0, 0);
      begin
         bit hs = 0;
         for (int k = 0; k < 20 && !hs; k++) begin
            @(negedge CLK);
            if (dmem_req_valid && dmem_req_ready) hs = 1;
         end
         if (!hs) check("flush_hs_timeout", 64'd0, 64'd1);
      end
      @(posedge CLK); #1; flush = 1'b1;
      @(posedge CLK); #1; flush = 1'b0;
      check("drain_in_ready0", 64'({in_ready, wb_valid}), 64'd0);
      @(posedge CLK); #1;
      check("drain_in_ready1", 64'({in_ready, wb_valid}), 64'd0);
      @(posedge CLK); #1;
      check("drain_done", 64'({in_ready, wb_valid}), 64'b10);
      rsp_delay_cfg = -1;

      // Trap record held while the consumer stalls
      wb_pct = 0;
      issue(2'd3, 5'd9, 3'd0, 2'd0, 32'hCAFE, 32'h80, 32'd0, 6'd4, 1'b1, 1);
      for (int i = 0; i < 5; i++) begin
         check("trap_hold", 64'({wb_valid, wb_trap, wb_cause, in_ready}), 64'({1'b1, 1'b1, 6'd4, 1'b0}));
         @(posedge CLK); #1;
      end
      wb_pct = 100;
      wait_idle();

      // Word load whose response carries a bus error
      issue(2'd0, 5'd10, 3'd2, 2'd0, 32'h0, 32'h3000, 32'd0, 6'd0, 1'b0, 1);
      wait_wb();
`ifdef MEM_BUS_ERR_EN
      check("err_trap", 64'({wb_trap, wb_cause, wb_we}), 64'({1'b1, 6'd5, 1'b0}));
`else
      check("noerr_load", 64'({wb_trap, wb_we, wb_data}), 64'({1'b0, 1'b1, 32'h0BAD_F00D}));
`endif
      wait_idle();

      // Randomized mixed traffic with random back-pressure on both sides
      ready_pct = 70; wb_pct = 60;
      for (int n = 0; n < 250; n++) begin
         if ($urandom_range(0, 9) < 5) begin
            ma = 2'($urandom_range(0, 1));
            f3 = (ma == 2'd1) ? 3'($urandom_range(0, 2)) : ld_f3[$urandom_range(0, 4)];
            ea = $urandom & 32'h0000_FFFF;
            if (f3[1:0] == 2'd1) ea[0] = 1'b0;
            if (f3[1:0] == 2'd2) ea[1:0] = 2'b00;
            issue(2'd0, 5'($urandom), f3, ma, $urandom, ea, $urandom, 6'd0, 1'($urandom), 1);
         end else begin
            typ = 2'($urandom_range(1, 3));
            issue(typ, 5'($urandom), 3'($urandom), 2'($urandom_range(0, 1)), $urandom, $urandom,
                  $urandom, 6'($urandom), 1'($urandom), 1);
         end
         repeat ($urandom_range(0, 2)) @(posedge CLK);
      end
      wb_pct = 100; ready_pct = 100;
      wait_idle();
      repeat (2) @(posedge CLK);
      check("wb_queue_empty", 64'(wb_q.size()), 64'd0);
      check("req_queue_empty", 64'(req_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
